// File: rtl/xrv_mem_arb.sv
// xrv_mem_arb: shares one memory bus between instruction fetch (IF) and
// load/store (D). Requests are accepted in issue order, a small order FIFO
// records who owns each outstanding transaction, and in-order bus responses
// are routed back to their owner. Fetches invalidated by a flush are dropped.
//
// Handshake: a requester holds *_req with stable fields until *_gnt is seen
// high in the same cycle; the bus accepts on m_req & m_gnt. A stalled bus
// request (m_req & ~m_gnt) locks the owner so the bus fields stay stable
// until the bus accepts, unless the locked owner withdraws its request.
module xrv_mem_arb #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic [31:0] m_addr,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_IF   = 2'd1,
    LOCK_D    = 2'd2
  } lock_t;

  lock_t           lock_q;
  lock_t           lock_d;
  logic [CW-1:0]   count;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [DEPTH-1:0] id_q;    // 1 = entry belongs to IF
  logic [DEPTH-1:0] disc_q;  // 1 = drop this response silently
  logic [SW-1:0]   starve;
  logic            err_q;

  logic full;
  logic sel_if;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full = (count == CW'(DEPTH));
  assign busy = (count != '0);
  assign err  = err_q;

  // Owner selection and next lock state.
  always_comb begin
    sel_if = 1'b0;
    lock_d = LOCK_NONE;
    case (lock_q)
      LOCK_IF: sel_if = if_req | ~d_req;
      LOCK_D:  sel_if = ~d_req;
      default: sel_if = ~d_req | (if_req & (starve == SW'(STARVE_MAX)));
    endcase
    if (m_req && !m_gnt) lock_d = sel_if ? LOCK_IF : LOCK_D;
  end

  // Bus request mirrors the selected requester; grants and responses.
  always_comb begin
    m_req     = rstb & (if_req | d_req) & ~full;
    m_addr    = sel_if ? if_addr : d_addr;
    m_we      = sel_if ? 1'b0    : d_we;
    m_be      = sel_if ? 4'hF    : d_be;
    m_wdata   = sel_if ? 32'h0   : d_wdata;
    push      = m_req & m_gnt;
    if_gnt    = push & sel_if;
    d_gnt     = push & ~sel_if;
    pop       = m_rvalid & busy;
    if_rvalid = pop & id_q[head] & ~disc_q[head] & ~flush;
    d_rvalid  = pop & ~id_q[head];
    if_rdata  = m_rdata;
    d_rdata   = m_rdata;
  end

  // Lock state register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) lock_q <= LOCK_NONE;
    else       lock_q <= lock_d;
  end

  // Outstanding count and order FIFO pointers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Order FIFO contents: flush marks all IF entries, push writes the tail.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      id_q   <= '0;
      disc_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush && id_q[i]) disc_q[i] <= 1'b1;
      end
      if (push) begin
        id_q[tail]   <= sel_if;
        disc_q[tail] <= flush & sel_if;
      end
    end
  end

  // Counts consecutive cycles IF loses to a D grant.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                     starve <= '0;
    else if (!if_req || if_gnt)    starve <= '0;
    else if (!full && d_gnt && (starve != SW'(STARVE_MAX)))
                                   starve <= starve + SW'(1);
  end

  // Sticky error: a response arrived with nothing outstanding.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                   err_q <= 1'b0;
    else if (m_rvalid && !busy)  err_q <= 1'b1;
  end

endmodule
